// File: rtl/procyon_ccu_arb_rr.sv
// N-requester CCU arbiter in front of the BIU controller: fixed-priority or round-robin
// selection, grant held for a whole bus transaction. Optional macro: PCYN_CCU_ARB_STARVE_EN.
module procyon_ccu_arb_rr #(
    parameter int unsigned OPTN_ADDR_WIDTH    = 32,
    parameter int unsigned OPTN_CCU_ARB_DEPTH = 3,
    parameter int unsigned OPTN_CCU_LINE_SIZE = 32,
    parameter int unsigned OPTN_ARB_MODE      = 0,
    parameter int unsigned OPTN_STARVE_LIMIT  = 8,
    localparam int unsigned CCU_LINE_WIDTH    = OPTN_CCU_LINE_SIZE * 8,
    localparam int unsigned ARB_IDX_WIDTH     =
        (OPTN_CCU_ARB_DEPTH > 1) ? $clog2(OPTN_CCU_ARB_DEPTH) : 1,
    localparam int unsigned PCYN_CCU_LEN_WIDTH  = 4,
    localparam int unsigned PCYN_BIU_LEN_WIDTH  = PCYN_CCU_LEN_WIDTH,
    localparam int unsigned PCYN_BIU_FUNC_WIDTH = 1,
    localparam logic [PCYN_BIU_FUNC_WIDTH-1:0] PCYN_BIU_FUNC_READ  = 1'b0,
    localparam logic [PCYN_BIU_FUNC_WIDTH-1:0] PCYN_BIU_FUNC_WRITE = 1'b1
) (
    input  logic                                                     clk,
    input  logic                                                     n_rst,
    input  logic [OPTN_CCU_ARB_DEPTH-1:0]                            i_ccu_arb_valid,
    input  logic [OPTN_CCU_ARB_DEPTH-1:0]                            i_ccu_arb_we,
    input  logic [OPTN_CCU_ARB_DEPTH-1:0][PCYN_CCU_LEN_WIDTH-1:0]    i_ccu_arb_len,
    input  logic [OPTN_CCU_ARB_DEPTH-1:0][OPTN_ADDR_WIDTH-1:0]       i_ccu_arb_addr,
    input  logic [OPTN_CCU_ARB_DEPTH-1:0][CCU_LINE_WIDTH-1:0]        i_ccu_arb_data,
    output logic [OPTN_CCU_ARB_DEPTH-1:0]                            o_ccu_arb_done,
    output logic [OPTN_CCU_ARB_DEPTH-1:0]                            o_ccu_arb_grant,
    output logic [CCU_LINE_WIDTH-1:0]                                o_ccu_arb_data,
    input  logic                                                     i_biu_done,
    input  logic [CCU_LINE_WIDTH-1:0]                                i_biu_data,
    output logic                                                     o_biu_en,
    output logic [PCYN_BIU_FUNC_WIDTH-1:0]                           o_biu_func,
    output logic [PCYN_BIU_LEN_WIDTH-1:0]                            o_biu_len,
    output logic [OPTN_ADDR_WIDTH-1:0]                               o_biu_addr,
    output logic [CCU_LINE_WIDTH-1:0]                                o_biu_data
);

    localparam int NUM_REQ = int'(OPTN_CCU_ARB_DEPTH);

    if (OPTN_CCU_ARB_DEPTH < 1 || OPTN_CCU_ARB_DEPTH > 16) begin : g_bad_depth
        $error("OPTN_CCU_ARB_DEPTH must be in 1..16");
    end
    if (OPTN_STARVE_LIMIT < 1) begin : g_bad_limit
        $error("OPTN_STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                             state_q;
    logic [NUM_REQ-1:0]                 grant_q;
    logic [NUM_REQ-1:0]                 done_q;
    logic [CCU_LINE_WIDTH-1:0]          rdata_q;
    logic                               biu_en_q;
    logic [PCYN_BIU_FUNC_WIDTH-1:0]     func_q;
    logic [PCYN_BIU_LEN_WIDTH-1:0]      len_q;
    logic [OPTN_ADDR_WIDTH-1:0]         addr_q;
    logic [CCU_LINE_WIDTH-1:0]          wdata_q;
    logic [ARB_IDX_WIDTH-1:0]           rr_ptr_q;

    logic                               win_found;
    logic [ARB_IDX_WIDTH-1:0]           win_idx;
    logic [NUM_REQ-1:0]                 win_onehot;
    logic [ARB_IDX_WIDTH-1:0]           next_ptr;
    logic                               sel_we;
    logic [PCYN_CCU_LEN_WIDTH-1:0]      sel_len;
    logic [OPTN_ADDR_WIDTH-1:0]         sel_addr;
    logic [CCU_LINE_WIDTH-1:0]          sel_wdata;

`ifdef PCYN_CCU_ARB_STARVE_EN
    localparam int unsigned STARVE_CNT_WIDTH = $clog2(OPTN_STARVE_LIMIT + 1);
    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(OPTN_STARVE_LIMIT);

    logic [NUM_REQ-1:0][STARVE_CNT_WIDTH-1:0] starve_cnt_q;
    logic [NUM_REQ-1:0]                       grant_now;
`endif

    // Winner selection; loops run high-to-low so the last hit is the highest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef PCYN_CCU_ARB_STARVE_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_ccu_arb_valid[i] && (starve_cnt_q[i] == STARVE_MAX)) begin
                win_found = 1'b1;
                win_idx   = ARB_IDX_WIDTH'(i);
            end
        end
`endif
        if (!win_found) begin
            if (OPTN_ARB_MODE == 0) begin
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (i_ccu_arb_valid[i]) begin
                        win_found = 1'b1;
                        win_idx   = ARB_IDX_WIDTH'(i);
                    end
                end
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    int idx;
                    idx = int'(32'(rr_ptr_q)) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    if (i_ccu_arb_valid[idx]) begin
                        win_found = 1'b1;
                        win_idx   = ARB_IDX_WIDTH'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = win_found && (win_idx == ARB_IDX_WIDTH'(i));
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_we    = i_ccu_arb_we[i];
                sel_len   = i_ccu_arb_len[i];
                sel_addr  = i_ccu_arb_addr[i];
                sel_wdata = i_ccu_arb_data[i];
            end
        end
    end

    // With a single requester this always yields 0, keeping the pointer constant.
    always_comb begin
        if (win_idx == ARB_IDX_WIDTH'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + ARB_IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            biu_en_q <= 1'b0;
            func_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q  <= StBusy;
                        grant_q  <= win_onehot;
                        biu_en_q <= 1'b1;
                        func_q   <= sel_we ? PCYN_BIU_FUNC_WRITE : PCYN_BIU_FUNC_READ;
                        len_q    <= sel_len;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        if (OPTN_ARB_MODE != 0) rr_ptr_q <= next_ptr;
                    end
                end
                StBusy: begin
                    if (i_biu_done) begin
                        state_q  <= StDone;
                        biu_en_q <= 1'b0;
                        rdata_q  <= i_biu_data;
                        done_q   <= grant_q;
                    end
                end
                StDone: begin
                    // Bubble cycle: the owner drops its valid here, so it cannot be regranted.
                    state_q <= StIdle;
                    grant_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PCYN_CCU_ARB_STARVE_EN
    assign grant_now = (state_q == StIdle) ? win_onehot : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            starve_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!i_ccu_arb_valid[i] || grant_now[i]) begin
                    starve_cnt_q[i] <= '0;
                end else if (!grant_q[i] && (starve_cnt_q[i] != STARVE_MAX)) begin
                    starve_cnt_q[i] <= starve_cnt_q[i] + STARVE_CNT_WIDTH'(1);
                end
            end
        end
    end
`endif

    assign o_ccu_arb_done  = done_q;
    assign o_ccu_arb_grant = grant_q;
    assign o_ccu_arb_data  = rdata_q;
    assign o_biu_en        = biu_en_q;
    assign o_biu_func      = func_q;
    assign o_biu_len       = len_q;
    assign o_biu_addr      = addr_q;
    assign o_biu_data      = wdata_q;

endmodule

// File: tb/tb_procyon_ccu_arb_rr.sv
// Bench for procyon_ccu_arb_rr: a fixed-priority N=3 instance and a round-robin N=4 instance,
// checked every cycle against a transaction-level reference model.
module tb_procyon_ccu_arb_rr;

    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives the fixed-priority instance, index 1 the round-robin one.
    logic [3:0]         in_valid [2];
    logic [3:0]         in_we    [2];
    logic [3:0][3:0]    in_len   [2];
    logic [3:0][31:0]   in_addr  [2];
    logic [3:0][255:0]  in_wdata [2];
    logic               in_bdone [2];
    logic [255:0]       in_bdata [2];

    logic [2:0]   fx_done, fx_grant;
    logic [255:0] fx_rdata, fx_bdata;
    logic         fx_en;
    logic [0:0]   fx_func;
    logic [3:0]   fx_len;
    logic [31:0]  fx_addr;

    logic [3:0]   rr_done, rr_grant;
    logic [255:0] rr_rdata, rr_bdata;
    logic         rr_en;
    logic [0:0]   rr_func;
    logic [3:0]   rr_len;
    logic [31:0]  rr_addr;

    procyon_ccu_arb_rr #(
        .OPTN_ADDR_WIDTH   (32),
        .OPTN_CCU_ARB_DEPTH(3),
        .OPTN_CCU_LINE_SIZE(32),
        .OPTN_ARB_MODE     (0),
        .OPTN_STARVE_LIMIT (LIMIT)
    ) dut_fx (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_ccu_arb_valid(in_valid[0][2:0]),
        .i_ccu_arb_we   (in_we[0][2:0]),
        .i_ccu_arb_len  (in_len[0][2:0]),
        .i_ccu_arb_addr (in_addr[0][2:0]),
        .i_ccu_arb_data (in_wdata[0][2:0]),
        .o_ccu_arb_done (fx_done),
        .o_ccu_arb_grant(fx_grant),
        .o_ccu_arb_data (fx_rdata),
        .i_biu_done     (in_bdone[0]),
        .i_biu_data     (in_bdata[0]),
        .o_biu_en       (fx_en),
        .o_biu_func     (fx_func),
        .o_biu_len      (fx_len),
        .o_biu_addr     (fx_addr),
        .o_biu_data     (fx_bdata)
    );

    procyon_ccu_arb_rr #(
        .OPTN_ADDR_WIDTH   (32),
        .OPTN_CCU_ARB_DEPTH(4),
        .OPTN_CCU_LINE_SIZE(32),
        .OPTN_ARB_MODE     (1),
        .OPTN_STARVE_LIMIT (LIMIT)
    ) dut_rr (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_ccu_arb_valid(in_valid[1]),
        .i_ccu_arb_we   (in_we[1]),
        .i_ccu_arb_len  (in_len[1]),
        .i_ccu_arb_addr (in_addr[1]),
        .i_ccu_arb_data (in_wdata[1]),
        .o_ccu_arb_done (rr_done),
        .o_ccu_arb_grant(rr_grant),
        .o_ccu_arb_data (rr_rdata),
        .i_biu_done     (in_bdone[1]),
        .i_biu_data     (in_bdata[1]),
        .o_biu_en       (rr_en),
        .o_biu_func     (rr_func),
        .o_biu_len      (rr_len),
        .o_biu_addr     (rr_addr),
        .o_biu_data     (rr_bdata)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = waiting, 1 = bus transaction open, 2 = completion bubble.
    int           nreq  [2];
    int           mode  [2];
    int           m_ph  [2];
    int           m_ptr [2];
    int           m_cnt [2][4];
    logic [3:0]   m_grant [2];
    logic [3:0]   m_done  [2];
    logic         m_en    [2];
    logic         m_func  [2];
    logic [3:0]   m_len   [2];
    logic [31:0]  m_addr  [2];
    logic [255:0] m_bdata [2];
    logic [255:0] m_rdata [2];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int pick(input int d);
`ifdef PCYN_CCU_ARB_STARVE_EN
        for (int i = 0; i < nreq[d]; i++) begin
            if (in_valid[d][i] && m_cnt[d][i] == LIMIT) return i;
        end
`endif
        for (int k = 0; k < nreq[d]; k++) begin
            int i;
            i = (mode[d] != 0) ? (m_ptr[d] + k) % nreq[d] : k;
            if (in_valid[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_ptr[d] = 0; m_grant[d] = '0; m_done[d] = '0; m_en[d] = 1'b0;
            m_func[d] = 1'b0; m_len[d] = '0; m_addr[d] = '0; m_bdata[d] = '0; m_rdata[d] = '0;
            for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int win;
            logic [3:0] old_grant;
            win = -1;
            old_grant = m_grant[d];
            m_done[d] = '0;
            if (m_ph[d] == 0) begin
                win = pick(d);
                if (win >= 0) begin
                    m_ph[d] = 1;
                    m_grant[d] = 4'(1 << win);
                    m_en[d] = 1'b1;
                    m_func[d] = in_we[d][win];
                    m_len[d] = in_len[d][win];
                    m_addr[d] = in_addr[d][win];
                    m_bdata[d] = in_wdata[d][win];
                    if (mode[d] != 0) m_ptr[d] = (win + 1) % nreq[d];
                end
            end else if (m_ph[d] == 1) begin
                if (in_bdone[d]) begin
                    m_ph[d] = 2;
                    m_en[d] = 1'b0;
                    m_rdata[d] = in_bdata[d];
                    m_done[d] = m_grant[d];
                end
            end else begin
                m_ph[d] = 0;
                m_grant[d] = '0;
            end
`ifdef PCYN_CCU_ARB_STARVE_EN
            for (int i = 0; i < nreq[d]; i++) begin
                if (!in_valid[d][i] || i == win) m_cnt[d][i] = 0;
                else if (!old_grant[i] && m_cnt[d][i] < LIMIT) m_cnt[d][i]++;
            end
`endif
        end
    endtask

    task automatic check_all();
        chk("fx_grant", {1'b0, fx_grant}, m_grant[0]);
        chk("fx_done",  {1'b0, fx_done},  m_done[0]);
        chk("fx_en",    fx_en,    m_en[0]);
        chk("fx_func",  fx_func,  m_func[0]);
        chk("fx_len",   fx_len,   m_len[0]);
        chk("fx_addr",  fx_addr,  m_addr[0]);
        chk("fx_bdata", fx_bdata, m_bdata[0]);
        chk("fx_rdata", fx_rdata, m_rdata[0]);
        chk("rr_grant", rr_grant, m_grant[1]);
        chk("rr_done",  rr_done,  m_done[1]);
        chk("rr_en",    rr_en,    m_en[1]);
        chk("rr_func",  rr_func,  m_func[1]);
        chk("rr_len",   rr_len,   m_len[1]);
        chk("rr_addr",  rr_addr,  m_addr[1]);
        chk("rr_bdata", rr_bdata, m_bdata[1]);
        chk("rr_rdata", rr_rdata, m_rdata[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (!n_rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = '0; in_we[d] = '0; in_len[d] = '0; in_addr[d] = '0;
            in_wdata[d] = '0; in_bdone[d] = 1'b0; in_bdata[d] = '0;
        end
    endtask

    // Close out whatever transaction is open and return both instances to idle.
    task automatic drain();
        in_valid[0] = '0; in_valid[1] = '0;
        in_bdone[0] = 1'b1; in_bdone[1] = 1'b1;
        repeat (3) step();
        in_bdone[0] = 1'b0; in_bdone[1] = 1'b0;
    endtask

    initial begin
        logic [255:0] line;
        logic         seen2;
        nreq[0] = 3; nreq[1] = 4;
        mode[0] = 0; mode[1] = 1;
        clear_inputs();
        model_reset();

        // Reset state
        n_rst = 1'b0;
        in_valid[0] = 4'b0111;
        repeat (2) step();
        chk("reset_grant", fx_grant, 3'b000);
        n_rst = 1'b1;
        in_valid[0] = '0;
        step();

        // Fixed priority: lowest valid index wins; valid dropped mid-transaction.
        in_valid[0] = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            in_addr[0][i] = $urandom();
            in_len[0][i] = 4'($urandom());
        end
        step();
        chk("fx_grant_110", fx_grant, 3'b010);
        chk("fx_en_busy", fx_en, 1'b1);
        in_valid[0] = '0;
        step();
        chk("fx_no_early_done", fx_done, 3'b000);
        in_bdone[0] = 1'b1;
        in_bdata[0] = 256'hDEAD_BEEF;
        step();
        in_bdone[0] = 1'b0;
        chk("fx_done_pulse", fx_done, 3'b010);
        chk("fx_rdata_cap", fx_rdata, 256'hDEAD_BEEF);
        chk("fx_grant_held", fx_grant, 3'b010);
        chk("fx_en_done", fx_en, 1'b0);
        step();
        chk("fx_done_once", fx_done, 3'b000);
        step();
        chk("fx_no_regrant", fx_grant, 3'b000);
        chk("fx_rdata_hold", fx_rdata, 256'hDEAD_BEEF);

        // Round-robin with every requester always valid.
        in_valid[1] = 4'hf;
        for (int t = 0; t < 5; t++) begin
            logic [3:0] exp_g;
            exp_g = 4'(1 << (t % 4));
            step();
            chk("rr_order", rr_grant, exp_g);
            step();
            in_bdone[1] = 1'b1;
            step();
            in_bdone[1] = 1'b0;
            step();
        end
        drain();

        // Write transaction; requester inputs change while the bus is busy.
        line = rand_line();
        in_valid[0] = 4'b0100;
        in_we[0] = 4'b0100;
        in_addr[0][2] = 32'h1000;
        in_wdata[0][2] = line;
        step();
        chk("wr_func", fx_func, 1'b1);
        chk("wr_addr", fx_addr, 32'h1000);
        chk("wr_data", fx_bdata, line);
        in_valid[0] = 4'b0111;
        in_we[0] = '0;
        in_addr[0][2] = 32'h2000;
        in_wdata[0][2] = ~line;
        step();
        chk("wr_addr_stable", fx_addr, 32'h1000);
        chk("wr_data_stable", fx_bdata, line);
        chk("wr_grant_stable", fx_grant, 3'b100);
        drain();

        // Reset while a transaction is open.
        in_valid[0] = 4'b0001;
        step();
        in_valid[0] = '0;
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk("rst_grant", fx_grant, 3'b000);
        chk("rst_en", fx_en, 1'b0);
        in_bdone[0] = 1'b1;
        step();
        chk("rst_no_done", fx_done, 3'b000);
        in_bdone[0] = 1'b0;
        n_rst = 1'b1;
        in_valid[0] = 4'b0010;
        step();
        chk("post_rst_grant", fx_grant, 3'b010);
        drain();

        // Requester 0 keeps re-requesting while requester 2 waits.
        seen2 = 1'b0;
        in_valid[0] = 4'b0101;
        in_bdone[0] = 1'b1;
        repeat (40) begin
            step();
            if (fx_grant[2]) seen2 = 1'b1;
        end
`ifdef PCYN_CCU_ARB_STARVE_EN
        chk("starve_req2_granted", seen2, 1'b1);
`else
        chk("fixed_req2_blocked", seen2, 1'b0);
`endif
        drain();

        // Randomized traffic on both instances.
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) begin
                    in_valid[d][i] = ($urandom_range(0, 4) < 3);
                    in_we[d][i] = 1'($urandom());
                    in_len[d][i] = 4'($urandom());
                    in_addr[d][i] = $urandom();
                    in_wdata[d][i] = rand_line();
                end
                in_bdone[d] = ($urandom_range(0, 2) == 0);
                in_bdata[d] = rand_line();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
